rv32i_id_stage: RTL and testbench

//  RV32I decode stage; consumes the fetch-stage outputs (inst, pc, pc+4) and produces the ID/EX pipeline register.

---
 rtl/rv32i_id_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rv32i_id_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_id_stage.sv
// rv32i_id_stage: RV32I decode stage with register file, immediate generator,
// main/ALU decoder, load-use hazard detection and the ID/EX pipeline register.
// Optional feature: define RF_BYPASS_EN for write-through register file reads.
module rv32i_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    input  logic        ex_mem_re_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        load_use_stall_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [3:0]  alu_op_o,
    output logic        a_sel_o,
    output logic        b_sel_o,
    output logic [2:0]  br_type_o,
    output logic        br_en_o,
    output logic        jump_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic [1:0]  wb_sel_o,
    output logic        reg_we_o,
    output logic        illegal_o
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [3:0] ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        a_sel;
        logic        b_sel;
        logic [2:0]  br_type;
        logic        br_en;
        logic        jump;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic [1:0]  wb_sel;
        logic        reg_we;
        logic        illegal;
    } idex_t;

    // A bubble carries no side effects; its PC points at the reset vector.
    localparam idex_t BUBBLE = '{pc: RESET_PC, pc4: RESET_PC + 32'd4, default: '0};

    // funct3 -> ALU op; alt selects SUB over ADD and SRA over SRL.
    function automatic logic [3:0] alu_sel(input logic [2:0] f, input logic alt);
        return f == 3'd0 ? (alt ? 4'd1 : 4'd0) :
               f == 3'd1 ? 4'd2 :
               f == 3'd2 ? 4'd3 :
               f == 3'd3 ? 4'd4 :
               f == 3'd4 ? 4'd5 :
               f == 3'd5 ? (alt ? 4'd7 : 4'd6) :
               f == 3'd6 ? 4'd8 : 4'd9;
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_rd, rs2_rd;
    logic        uses_rs1, uses_rs2, known, nop;
    idex_t       dec, idex_d, idex_q;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    assign opc   = inst_i[6:0];
    assign f3    = inst_i[14:12];
    assign alt   = inst_i[30];
    assign rs1_f = inst_i[19:15];
    assign rs2_f = inst_i[24:20];
    assign rd_f  = inst_i[11:7];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

`ifdef RF_BYPASS_EN
    assign rs1_rd = rs1_f == 5'd0 ? 32'd0 : (wb_we_i && wb_rd_i == rs1_f) ? wb_data_i : rf_q[rs1_f];
    assign rs2_rd = rs2_f == 5'd0 ? 32'd0 : (wb_we_i && wb_rd_i == rs2_f) ? wb_data_i : rf_q[rs2_f];
`else
    assign rs1_rd = rs1_f == 5'd0 ? 32'd0 : rf_q[rs1_f];
    assign rs2_rd = rs2_f == 5'd0 ? 32'd0 : rf_q[rs2_f];
`endif

    assign load_use_stall_o = ex_mem_re_i && ex_rd_i != 5'd0 &&
                              ((uses_rs1 && ex_rd_i == rs1_f) || (uses_rs2 && ex_rd_i == rs2_f));

    // Main decoder: controls, immediate and operand usage for the fetched word.
    always_comb begin
        dec          = '0;
        dec.rs1_data = rs1_rd;
        dec.rs2_data = rs2_rd;
        dec.pc       = pc_i;
        dec.pc4      = pc4_i;
        dec.rs1      = rs1_f;
        dec.rs2      = rs2_f;
        dec.rd       = rd_f;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        known        = 1'b1;
        nop          = 1'b0;
        case (opc)
            OP_REG: begin
                dec.alu_op = alu_sel(f3, alt);
                dec.reg_we = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_IMM: begin
                dec.alu_op = alu_sel(f3, alt && f3 == 3'd5);
                dec.b_sel  = 1'b1;
                dec.imm    = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, rs2_f} : imm_i;
                dec.reg_we = 1'b1;
                uses_rs1   = 1'b1;
            end
            OP_LUI: begin
                dec.alu_op = ALU_PASS_B;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec.reg_we = 1'b1;
            end
            OP_AUIPC: begin
                dec.a_sel  = 1'b1;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_u;
                dec.reg_we = 1'b1;
            end
            OP_JAL: begin
                dec.a_sel  = 1'b1;
                dec.b_sel  = 1'b1;
                dec.imm    = imm_j;
                dec.jump   = 1'b1;
                dec.wb_sel = 2'd2;
                dec.reg_we = 1'b1;
            end
            OP_JALR: begin
                dec.b_sel  = 1'b1;
                dec.imm    = imm_i;
                dec.jump   = 1'b1;
                dec.wb_sel = 2'd2;
                dec.reg_we = 1'b1;
                uses_rs1   = 1'b1;
            end
            OP_BR: begin
                dec.a_sel   = 1'b1;
                dec.b_sel   = 1'b1;
                dec.imm     = imm_b;
                dec.br_en   = 1'b1;
                dec.br_type = f3;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_LD: begin
                dec.b_sel    = 1'b1;
                dec.imm      = imm_i;
                dec.mem_re   = 1'b1;
                dec.mem_size = f3;
                dec.wb_sel   = 2'd1;
                dec.reg_we   = 1'b1;
                uses_rs1     = 1'b1;
            end
            OP_ST: begin
                dec.b_sel    = 1'b1;
                dec.imm      = imm_s;
                dec.mem_we   = 1'b1;
                dec.mem_size = f3;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_FENCE, OP_SYS: nop = 1'b1;
            default: known = 1'b0;
        endcase
        if (nop || !known) dec = BUBBLE;
        dec.illegal = !known && inst_i != 32'h0;
    end

    // ID/EX next value: flush beats stall, stall holds, load-use inserts a bubble.
    always_comb begin
        idex_d = flush_i ? BUBBLE : stall_i ? idex_q : load_use_stall_o ? BUBBLE : dec;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idex_q <= BUBBLE;
        else        idex_q <= idex_d;
    end

    // Register file write port; x0 is never written so it always reads 0.
    always_comb begin
        rf_d = rf_q;
        if (wb_we_i && wb_rd_i != 5'd0) rf_d[wb_rd_i] = wb_data_i;
    end

    // Register file storage, cleared by reset and independent of stall/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    assign rs1_data_o = idex_q.rs1_data;
    assign rs2_data_o = idex_q.rs2_data;
    assign imm_o      = idex_q.imm;
    assign pc_o       = idex_q.pc;
    assign pc4_o      = idex_q.pc4;
    assign rs1_o      = idex_q.rs1;
    assign rs2_o      = idex_q.rs2;
    assign rd_o       = idex_q.rd;
    assign alu_op_o   = idex_q.alu_op;
    assign a_sel_o    = idex_q.a_sel;
    assign b_sel_o    = idex_q.b_sel;
    assign br_type_o  = idex_q.br_type;
    assign br_en_o    = idex_q.br_en;
    assign jump_o     = idex_q.jump;
    assign mem_re_o   = idex_q.mem_re;
    assign mem_we_o   = idex_q.mem_we;
    assign mem_size_o = idex_q.mem_size;
    assign wb_sel_o   = idex_q.wb_sel;
    assign reg_we_o   = idex_q.reg_we;
    assign illegal_o  = idex_q.illegal;

endmodule

// File: tb/tb_rv32i_id_stage.sv
// tb_rv32i_id_stage: randomized and directed checks of rv32i_id_stage against a behavioural model.
module tb_rv32i_id_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, IMM = 7'b0010011;
    localparam logic [6:0] REG = 7'b0110011, FENCE = 7'b0001111, SYS = 7'b1110011;

    logic        clk = 1'b0, rst_n = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic        ex_mem_re_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] inst_i = '0, pc_i = '0, pc4_i = '0, wb_data_i = '0;
    logic [4:0]  ex_rd_i = '0, wb_rd_i = '0;
    logic        load_use_stall_o, a_sel_o, b_sel_o, br_en_o, jump_o, mem_re_o, mem_we_o, reg_we_o, illegal_o;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o, pc_o, pc4_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  br_type_o, mem_size_o;
    logic [1:0]  wb_sel_o;

    typedef struct packed {
        logic [31:0] rs1_data, rs2_data, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic        a_sel, b_sel;
        logic [2:0]  br_type;
        logic        br_en, jump, mem_re, mem_we;
        logic [2:0]  mem_size;
        logic [1:0]  wb_sel;
        logic        reg_we, illegal;
    } exp_t;

    exp_t        act, exp_q, held;
    logic [31:0] regs [32];
    int          alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [6:0]  rand_ops [14] = '{REG, REG, IMM, IMM, LD, ST, BR, JAL, JALR, LUI, AUIPC, FENCE, SYS, 7'h7F};
    int          checks = 0, errors = 0;

    rv32i_id_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .inst_i(inst_i),
        .pc_i(pc_i), .pc4_i(pc4_i), .ex_mem_re_i(ex_mem_re_i), .ex_rd_i(ex_rd_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .load_use_stall_o(load_use_stall_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .pc_o(pc_o), .pc4_o(pc4_o),
        .alu_op_o(alu_op_o), .a_sel_o(a_sel_o), .b_sel_o(b_sel_o), .br_type_o(br_type_o),
        .br_en_o(br_en_o), .jump_o(jump_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .mem_size_o(mem_size_o), .wb_sel_o(wb_sel_o), .reg_we_o(reg_we_o), .illegal_o(illegal_o)
    );

    assign act = {rs1_data_o, rs2_data_o, imm_o, pc_o, pc4_o, rs1_o, rs2_o, rd_o, alu_op_o,
                  a_sel_o, b_sel_o, br_type_o, br_en_o, jump_o, mem_re_o, mem_we_o,
                  mem_size_o, wb_sel_o, reg_we_o, illegal_o};

    always #5 clk = ~clk;

    function automatic exp_t bubble();
        exp_t e;
        e = '0;
        e.pc = RPC;
        e.pc4 = RPC + 32'd4;
        return e;
    endfunction

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        return 4'(alu_tab[f3] + ((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (wb_we_i && wb_rd_i == idx) return wb_data_i;
`endif
        return regs[idx];
    endfunction

    function automatic logic model_lu(input logic [31:0] in, input logic re, input logic [4:0] rd);
        logic u1, u2;
        u1 = in[6:0] inside {JALR, BR, LD, ST, IMM, REG};
        u2 = in[6:0] inside {REG, ST, BR};
        return re && rd != 5'd0 && ((u1 && rd == in[19:15]) || (u2 && rd == in[24:20]));
    endfunction

    function automatic exp_t model_decode(input logic [31:0] in, input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        logic [2:0] f3;
        int ia, is, ib, ij;
        f3 = in[14:12];
        ia = int'(in[31:20]) - (in[31] ? 4096 : 0);
        is = int'({in[31:25], in[11:7]}) - (in[31] ? 4096 : 0);
        ib = int'(in[7]) * 2048 + int'(in[30:25]) * 32 + int'(in[11:8]) * 2 - (in[31] ? 4096 : 0);
        ij = int'(in[19:12]) * 4096 + int'(in[20]) * 2048 + int'(in[30:21]) * 2 - (in[31] ? 1048576 : 0);
        e = '0;
        e.rs1_data = model_read(in[19:15]);
        e.rs2_data = model_read(in[24:20]);
        e.pc = pc;
        e.pc4 = pc4;
        e.rs1 = in[19:15];
        e.rs2 = in[24:20];
        e.rd = in[11:7];
        case (in[6:0])
            REG:   begin e.alu_op = alu_code(f3, in[30]); e.reg_we = 1; end
            IMM:   begin e.alu_op = alu_code(f3, f3 == 3'd5 && in[30]); e.b_sel = 1; e.reg_we = 1;
                         e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(in[24:20]) : 32'(ia); end
            LUI:   begin e.alu_op = 4'd10; e.b_sel = 1; e.imm = in & 32'hFFFFF000; e.reg_we = 1; end
            AUIPC: begin e.a_sel = 1; e.b_sel = 1; e.imm = in & 32'hFFFFF000; e.reg_we = 1; end
            JAL:   begin e.a_sel = 1; e.b_sel = 1; e.imm = 32'(ij); e.jump = 1; e.wb_sel = 2; e.reg_we = 1; end
            JALR:  begin e.b_sel = 1; e.imm = 32'(ia); e.jump = 1; e.wb_sel = 2; e.reg_we = 1; end
            BR:    begin e.a_sel = 1; e.b_sel = 1; e.imm = 32'(ib); e.br_en = 1; e.br_type = f3; end
            LD:    begin e.b_sel = 1; e.imm = 32'(ia); e.mem_re = 1; e.mem_size = f3; e.wb_sel = 1; e.reg_we = 1; end
            ST:    begin e.b_sel = 1; e.imm = 32'(is); e.mem_we = 1; e.mem_size = f3; end
            default: begin
                e = bubble();
                e.illegal = in != 32'h0 && in[6:0] != FENCE && in[6:0] != SYS;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] in;
        int k;
        k = $urandom_range(0, 14);
        if (k == 14) return 32'h0;
        in = $urandom;
        in[6:0] = rand_ops[k];
        in[11:7] = 5'($urandom_range(0, 7));
        in[19:15] = 5'($urandom_range(0, 7));
        in[24:20] = 5'($urandom_range(0, 7));
        return in;
    endfunction

    task automatic set_inst(input logic [31:0] in);
        inst_i = in;
        pc_i = $urandom & 32'hFFFF_FFFC;
        pc4_i = pc_i + 32'd4;
    endtask

    task automatic tick();
        exp_t nxt;
        nxt = flush_i ? bubble() : stall_i ? exp_q :
              model_lu(inst_i, ex_mem_re_i, ex_rd_i) ? bubble() : model_decode(inst_i, pc_i, pc4_i);
        @(posedge clk);
        if (rst_n) begin
            exp_q = nxt;
            if (wb_we_i && wb_rd_i != 5'd0) regs[wb_rd_i] = wb_data_i;
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (act !== bubble()) begin errors++; $display("FAIL reset_init: got %h want %h", act, bubble()); end
        rst_n = 1'b1;
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hCAFE0005;
        set_inst(32'h0);
        tick();
        wb_we_i = 1'b0;
        set_inst(32'h00028093);
        tick();
        checks++;
        if (rs1_data_o !== 32'hCAFE0005) begin errors++; $display("FAIL reset_pre_x5: got %h want cafe0005", rs1_data_o); end
        ex_mem_re_i = 1'b1; ex_rd_i = 5'd5;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        exp_q = bubble();
        checks++;
        if (act !== bubble()) begin errors++; $display("FAIL reset_async: got %h want %h", act, bubble()); end
        ex_mem_re_i = 1'b0;
        #1;
        checks++;
        if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL reset_lu_drop: got %b want 0", load_use_stall_o); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (rs1_data_o !== 32'h0 || act !== exp_q) begin
            errors++; $display("FAIL reset_x5_cleared: got %h want %h", act, exp_q);
        end
    endtask

    task automatic test_addi();
        set_inst(32'hFFB00093);
        tick();
        checks++;
        if ({alu_op_o, b_sel_o, imm_o, rd_o, reg_we_o, wb_sel_o} !== {4'd0, 1'b1, 32'hFFFFFFFB, 5'd1, 1'b1, 2'd0}) begin
            errors++; $display("FAIL addi_fields: got %h want %h", act, exp_q);
        end
        checks++;
        if (act !== exp_q) begin errors++; $display("FAIL addi_model: got %h want %h", act, exp_q); end
    endtask

    task automatic test_load_use();
        ex_mem_re_i = 1'b1; ex_rd_i = 5'd2;
        set_inst(32'h004101B3);
        #1;
        checks++;
        if (load_use_stall_o !== 1'b1) begin errors++; $display("FAIL lu_rs1: got %b want 1", load_use_stall_o); end
        tick();
        checks++;
        if (act !== bubble()) begin errors++; $display("FAIL lu_bubble: got %h want %h", act, bubble()); end
        ex_rd_i = 5'd4;
        #1;
        checks++;
        if (load_use_stall_o !== 1'b1) begin errors++; $display("FAIL lu_rs2: got %b want 1", load_use_stall_o); end
        ex_rd_i = 5'd0;
        #1;
        checks++;
        if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL lu_rd0: got %b want 0", load_use_stall_o); end
        ex_rd_i = 5'd2;
        set_inst(32'h12345137);
        #1;
        checks++;
        if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL lu_lui: got %b want 0", load_use_stall_o); end
        ex_rd_i = 5'd4;
        set_inst(32'h00400093);
        #1;
        checks++;
        if (load_use_stall_o !== 1'b0) begin errors++; $display("FAIL lu_itype_rs2: got %b want 0", load_use_stall_o); end
        tick();
        checks++;
        if (act !== exp_q || imm_o !== 32'd4) begin errors++; $display("FAIL lu_no_hazard: got %h want %h", act, exp_q); end
        ex_mem_re_i = 1'b0; ex_rd_i = 5'd0;
    endtask

    task automatic test_flush_stall();
        set_inst(32'hFFB00093);
        tick();
        flush_i = 1'b1; stall_i = 1'b1;
        set_inst(32'h004101B3);
        tick();
        checks++;
        if (act !== bubble()) begin errors++; $display("FAIL flush_stall_bubble: got %h want %h", act, bubble()); end
        flush_i = 1'b0; stall_i = 1'b0;
        tick();
        held = exp_q;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inst(rand_inst());
            tick();
            checks++;
            if (act !== held) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, act, held); end
        end
        stall_i = 1'b0;
        set_inst(32'h00400093);
        tick();
        checks++;
        if (act !== exp_q || imm_o !== 32'd4 || rd_o !== 5'd1) begin
            errors++; $display("FAIL stall_release: got %h want %h", act, exp_q);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        wb_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h11111111;
        set_inst(32'h0);
        tick();
        wb_data_i = 32'hDEADBEEF;
        set_inst(32'h00038093);
        tick();
`ifdef RF_BYPASS_EN
        want = 32'hDEADBEEF;
`else
        want = 32'h11111111;
`endif
        checks++;
        if (rs1_data_o !== want) begin errors++; $display("FAIL bypass_same_cycle: got %h want %h", rs1_data_o, want); end
        wb_we_i = 1'b0;
        tick();
        checks++;
        if (rs1_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_after: got %h want deadbeef", rs1_data_o); end
        wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hFFFFFFFF;
        set_inst(32'h00000093);
        tick();
        checks++;
        if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_same_cycle: got %h want 0", rs1_data_o); end
        wb_we_i = 1'b0;
        tick();
        checks++;
        if (rs1_data_o !== 32'h0 || act !== exp_q) begin errors++; $display("FAIL x0_after: got %h want %h", act, exp_q); end
    endtask

    task automatic test_imm_illegal();
        set_inst(32'hFE000EE3);
        tick();
        checks++;
        if ({imm_o, br_en_o, br_type_o, a_sel_o, b_sel_o, reg_we_o} !== {32'hFFFFFFFC, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL beq: got %h want %h", act, exp_q);
        end
        set_inst(32'h008000EF);
        tick();
        checks++;
        if ({jump_o, wb_sel_o, imm_o, reg_we_o, a_sel_o} !== {1'b1, 2'd2, 32'd8, 1'b1, 1'b1}) begin
            errors++; $display("FAIL jal: got %h want %h", act, exp_q);
        end
        set_inst(32'hFFFFFFFF);
        tick();
        checks++;
        if (illegal_o !== 1'b1 || reg_we_o !== 1'b0 || pc_o !== RPC) begin
            errors++; $display("FAIL illegal: got %h want %h", act, exp_q);
        end
        set_inst(32'h0);
        tick();
        checks++;
        if (act !== bubble()) begin errors++; $display("FAIL zero_inst: got %h want %h", act, bubble()); end
        set_inst(32'h00000073);
        tick();
        checks++;
        if (act !== bubble()) begin errors++; $display("FAIL ecall_nop: got %h want %h", act, bubble()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            ex_mem_re_i = ($urandom_range(0, 2) == 0);
            ex_rd_i = 5'($urandom_range(0, 7));
            wb_we_i = $urandom_range(0, 1) == 1;
            wb_rd_i = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            set_inst(rand_inst());
            #1;
            checks++;
            if (load_use_stall_o !== model_lu(inst_i, ex_mem_re_i, ex_rd_i)) begin
                errors++; $display("FAIL rand_lu[%0d]: got %b want %b inst %h", n, load_use_stall_o,
                                   model_lu(inst_i, ex_mem_re_i, ex_rd_i), inst_i);
            end
            tick();
            checks++;
            if (act !== exp_q) begin errors++; $display("FAIL rand_idex[%0d]: got %h want %h", n, act, exp_q); end
        end
        stall_i = 1'b0; flush_i = 1'b0; ex_mem_re_i = 1'b0; wb_we_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        exp_q = bubble();
        test_reset();
        test_addi();
        test_load_use();
        test_flush_stall();
        test_bypass();
        test_imm_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
